req_ack_responder: RTL

//   Request/acknowledge responder: generates the antecedent/consequent pair (req -> ack)

---
 rtl/req_ack_pkg.sv | 14 +
 rtl/req_ack_responder_latency_counter.sv | 36 +++
 rtl/req_ack_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/req_ack_pkg.sv
// Shared types and limits for the req/ack responder.
// Imported by the FSM top and its latency counter.
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } req_ack_state_e;

  localparam int unsigned MAX_LATENCY = 15;
  localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/req_ack_responder_latency_counter.sv
// Down-counter that times the WAIT phase of a transaction.
// Flags the final WAIT cycle so the FSM can move to ACK.
module latency_counter
  import req_ack_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/req_ack_responder.sv
// Request/acknowledge responder: captures a word on req and
// returns it with a one-cycle ack LATENCY clocks later.
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic [7:0]        ack_count,
  output logic [7:0]        abort_cnt
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("req_ack_responder: LATENCY must be 1..15");
  end

  localparam bit SINGLE = (LATENCY == 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  req_ack_state_e    state_q;
  logic              ack_q;
  logic              busy_q;
  logic [DATA_W-1:0] data_q;
  logic [7:0]        ack_cnt_q;
  logic [7:0]        abort_q;

  logic cnt_load;
  logic cnt_en;
  logic cnt_last;

  assign cnt_load = (state_q == IDLE) && req && !SINGLE;
  assign cnt_en   = (state_q == WAIT) && req;

  latency_counter u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(LOAD_VAL),
    .en      (cnt_en),
    .last    (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
      ack_cnt_q <= '0;
      abort_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            data_q <= data_in;
            busy_q <= 1'b1;
            if (SINGLE) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            abort_q <= abort_q + 8'd1;
          end else if (cnt_last) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
          end
        end
        ACK: begin
          state_q   <= IDLE;
          ack_q     <= 1'b0;
          busy_q    <= 1'b0;
          ack_cnt_q <= ack_cnt_q + 8'd1;
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign data_out  = data_q;
  assign ack_count = ack_cnt_q;
  assign abort_cnt = abort_q;

`ifndef SYNTHESIS
  // Shadow timer: reaches 1 on the edge where the ack must be seen;
  // an abort clears it so the obligation is dropped.
  logic [CNT_W-1:0] chk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_q <= '0;
    end else if (state_q == IDLE && req) begin
      chk_q <= CNT_W'(LATENCY);
    end else if (state_q == WAIT && !req) begin
      chk_q <= '0;
    end else if (chk_q != '0) begin
      chk_q <= chk_q - 1'b1;
    end
  end

  a_resp: assert property (
    @(posedge clk) disable iff (rst)
    (chk_q == CNT_W'(1)) |-> ack_q);

  a_pulse: assert property (
    @(posedge clk) disable iff (rst)
    ack_q |=> !ack_q);

  a_busy: assert property (
    @(posedge clk) disable iff (rst)
    ack_q |-> busy_q);

  a_idle: assert property (
    @(posedge clk) disable iff (rst)
    !busy_q |-> !ack_q);

  c_b2b: cover property (
    @(posedge clk) disable iff (rst)
    ack_q && $past(ack_q, LATENCY + 1));
`endif

endmodule
